// File: rtl/letreiro_sequenciador.sv
// rtl/letreiro_sequenciador.sv - frame-aligned column scan and scroll scheduler for the 5x7 marquee
module letreiro_sequenciador #(
    parameter int SCAN_DIV        = 1000,
    parameter int GUARD           = 2,
    parameter int FRAMES_PER_STEP = 10
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ch0,
    input  logic       ch1,
    output logic [2:0] col_idx,
    output logic [6:0] col_sel,
    output logic       blank,
    output logic       frame_start,
    output logic       step,
    output logic       dir,
    output logic       load,
    output logic [1:0] mode
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [DW-1:0] DCNT_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] GUARD_V   = DW'(GUARD);
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_STATIC = 2'b11
    } mode_e;

    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    req_q, req_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [2:0]    col_q, col_d;
    logic [6:0]    col_sel_q, col_sel_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    mode_e         mode_q, mode_d;
    logic          dir_q, dir_d;
    logic          blank_q, blank_d;
    logic          fs_q, fs_d;
    logic          step_q, step_d;
    logic          load_q, load_d;

    logic          dwell_end;
    logic          frame_end;
    logic          scrolling;
    logic [1:0]    next_mode_bits;

    // Next-state: dwell/column scan, frame-boundary mode decision, registered output decode
    always_comb begin
        sync1_d   = {ch1, ch0};
        req_d     = sync1_q;
        dcnt_d    = dcnt_q + 1'b1;
        col_d     = col_q;
        fcnt_d    = fcnt_q;
        mode_d    = mode_q;
        dir_d     = dir_q;
        fs_d      = 1'b0;
        step_d    = 1'b0;
        load_d    = 1'b0;

        dwell_end = (dcnt_q == DCNT_LAST);
        frame_end = dwell_end && (col_q == 3'd6);
        scrolling = (mode_q == MODE_LEFT) || (mode_q == MODE_RIGHT);

        if (dwell_end) begin
            dcnt_d = '0;
            col_d  = (col_q == 3'd6) ? 3'd0 : col_q + 3'd1;
        end

        // Mode, reload and scroll decisions only happen at the frame seam so no frame tears
        if (frame_end) begin
            fs_d = 1'b1;
            if (req_q != mode_q) begin
                mode_d = mode_e'(req_q);
                load_d = 1'b1;
                fcnt_d = '0;
            end else if (scrolling && (fcnt_q == FCNT_LAST)) begin
                step_d = 1'b1;
                fcnt_d = '0;
            end else begin
                fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
            end
        end

        next_mode_bits = mode_d;
        if ((mode_d == MODE_LEFT) || (mode_d == MODE_RIGHT)) begin
            dir_d = next_mode_bits[1];
        end

        col_sel_d = 7'b0000001 << col_d;
        blank_d   = (dcnt_d < GUARD_V) || (mode_d == MODE_OFF);
    end

    // State register with synchronous active-high reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q   <= 2'b00;
            req_q     <= 2'b00;
            dcnt_q    <= '0;
            col_q     <= 3'd0;
            col_sel_q <= 7'b0000001;
            fcnt_q    <= '0;
            mode_q    <= MODE_OFF;
            dir_q     <= 1'b0;
            blank_q   <= 1'b1;
            fs_q      <= 1'b0;
            step_q    <= 1'b0;
            load_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            req_q     <= req_d;
            dcnt_q    <= dcnt_d;
            col_q     <= col_d;
            col_sel_q <= col_sel_d;
            fcnt_q    <= fcnt_d;
            mode_q    <= mode_d;
            dir_q     <= dir_d;
            blank_q   <= blank_d;
            fs_q      <= fs_d;
            step_q    <= step_d;
            load_q    <= load_d;
        end
    end

    assign col_idx     = col_q;
    assign col_sel     = col_sel_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;
    assign step        = step_q;
    assign dir         = dir_q;
    assign load        = load_q;
    assign mode        = mode_q;

endmodule

// File: tb/tb_letreiro_sequenciador.sv
// tb/tb_letreiro_sequenciador.sv - self-checking bench for letreiro_sequenciador
module tb_letreiro_sequenciador;

    localparam int SD    = 4;
    localparam int G     = 1;
    localparam int FPS   = 2;
    localparam int FRAME = 7 * SD;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ch0 = 1'b0;
    logic       ch1 = 1'b0;
    logic [2:0] col_idx;
    logic [6:0] col_sel;
    logic       blank;
    logic       frame_start;
    logic       step;
    logic       dir;
    logic       load;
    logic [1:0] mode;

    letreiro_sequenciador #(
        .SCAN_DIV       (SD),
        .GUARD          (G),
        .FRAMES_PER_STEP(FPS)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ch0        (ch0),
        .ch1        (ch1),
        .col_idx    (col_idx),
        .col_sel    (col_sel),
        .blank      (blank),
        .frame_start(frame_start),
        .step       (step),
        .dir        (dir),
        .load       (load),
        .mode       (mode)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    int         c;
    logic [1:0] hist [0:8191];
    logic [1:0] ch_cur;
    logic [1:0] m_mode;
    logic       m_dir;
    int         k0;
    int         last_ev;
    int         steps_total;
    int         loads_total;

    // Model: cycle c after reset release; frame k = c/FRAME; decision at frame k uses the
    // switch value applied 3 cycles before that frame's first cycle (2 sync stages + boundary).
    task automatic check_and_drive();
        logic [16:0] exp_v;
        logic [16:0] obs_v;
        logic [6:0]  sel;
        logic [1:0]  r;
        logic        fs, ld, st, bl;
        int          dc, col, k;
        dc  = c % SD;
        col = (c / SD) % 7;
        k   = c / FRAME;
        fs  = (c % FRAME == 0) && (c > 0);
        ld  = 1'b0;
        st  = 1'b0;
        if (fs) begin
            r = hist[c - 3];
            if (r != m_mode) begin
                ld     = 1'b1;
                m_mode = r;
                k0     = k;
                if (r == 2'b01 || r == 2'b10) m_dir = r[1];
            end else if ((m_mode == 2'b01 || m_mode == 2'b10) && ((k - k0) % FPS == 0)) begin
                st = 1'b1;
            end
        end
        sel   = 7'(1 << col);
        bl    = (dc < G) || (m_mode == 2'b00);
        exp_v = {3'(col), sel, bl, fs, st, ld, m_mode, m_dir};
        obs_v = {col_idx, col_sel, blank, frame_start, step, load, mode, dir};
        checks++;
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL cycle_state c=%0d observed=%b expected=%b (col,sel,blank,fs,step,load,mode,dir)",
                   c, obs_v, exp_v);
        end
        if (step === 1'b1) begin
            steps_total++;
            if (last_ev >= 0) begin
                checks++;
                assert (c - last_ev === FPS * FRAME) else begin
                    errors++;
                    $error("FAIL step_interval observed=%0d expected=%0d", c - last_ev, FPS * FRAME);
                end
            end
            last_ev = c;
        end
        if (load === 1'b1) begin
            loads_total++;
            last_ev = c;
        end
        ch0 = ch_cur[0];
        ch1 = ch_cur[1];
        if (c < 8192) hist[c] = ch_cur;
        c++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            check_and_drive();
        end
    endtask

    task automatic model_reset();
        c       = 0;
        m_mode  = 2'b00;
        m_dir   = 1'b0;
        k0      = 0;
        last_ev = -1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        check_and_drive();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        check_and_drive();
    endtask

    task automatic wait_offset(input int off);
        while (c % FRAME != off) tick(1);
    endtask

    int s0, l0;

    initial begin
        ch_cur      = 2'b00;
        steps_total = 0;
        loads_total = 0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        check_and_drive();

        // Mode 00: scanning with blank held, no step/load
        tick(2 * FRAME + $urandom_range(0, 20));
        checks++;
        assert (steps_total + loads_total === 0) else begin
            errors++;
            $error("FAIL idle_pulses observed=%0d expected=0", steps_total + loads_total);
        end

        // Scroll left, entered early in a frame
        wait_offset($urandom_range(1, 10));
        ch_cur = 2'b01;
        tick(5 * FRAME);
        checks++;
        assert (mode === 2'b01 && dir === 1'b0) else begin
            errors++;
            $error("FAIL mode_left observed=%b/%b expected=01/0", mode, dir);
        end

        // Switch to scroll right
        wait_offset($urandom_range(0, 20));
        ch_cur = 2'b10;
        tick(3 * FRAME);
        checks++;
        assert (mode === 2'b10 && dir === 1'b1) else begin
            errors++;
            $error("FAIL mode_right observed=%b/%b expected=10/1", mode, dir);
        end

        // Back to left, then glitch 01->11->01 between frame boundaries
        ch_cur = 2'b01;
        tick(3 * FRAME);
        wait_offset(2);
        l0 = loads_total;
        ch_cur = 2'b11;
        tick($urandom_range(1, 8));
        ch_cur = 2'b01;
        tick(3 * FRAME);
        checks++;
        assert (loads_total === l0 && mode === 2'b01) else begin
            errors++;
            $error("FAIL glitch observed loads=%0d mode=%b expected loads=%0d mode=01",
                   loads_total - l0, mode, 0);
        end

        // Static mode: one load, no steps for 10 frames, dir held
        ch_cur = 2'b11;
        tick(FRAME + 3);
        s0 = steps_total;
        tick(10 * FRAME);
        checks++;
        assert (steps_total === s0 && mode === 2'b11 && dir === 1'b0) else begin
            errors++;
            $error("FAIL static observed steps=%0d mode=%b dir=%b expected 0/11/0",
                   steps_total - s0, mode, dir);
        end

        // Mid-frame reset at column 4 while scrolling right
        ch_cur = 2'b10;
        tick(2 * FRAME);
        while (((c / SD) % 7) != 4) tick(1);
        do_reset();
        tick(3 * FRAME);

        // Randomized switch activity
        repeat (25) begin
            ch_cur = 2'($urandom_range(0, 3));
            tick($urandom_range(1, 70));
        end
        tick(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
